// File: rtl/set_pkg.sv
// Shared encodings for the set-mode sequencer: pages, adjust targets,
// per-page field counts and digit blink masks.
package set_pkg;

  localparam int unsigned NUM_BTN  = 4;
  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_NEXT = 1;
  localparam int unsigned BTN_UP   = 2;
  localparam int unsigned BTN_DN   = 3;

  typedef enum logic [1:0] {
    PG_RUN   = 2'd0,
    PG_TIME  = 2'd1,
    PG_DATE  = 2'd2,
    PG_ALARM = 2'd3
  } page_e;

  typedef enum logic [2:0] {
    TGT_NONE = 3'd0,
    TGT_HR   = 3'd1,
    TGT_MIN  = 3'd2,
    TGT_SEC  = 3'd3,
    TGT_MM   = 3'd4,
    TGT_DD   = 3'd5,
    TGT_AHR  = 3'd6,
    TGT_AMIN = 3'd7
  } tgt_e;

  localparam logic [1:0] FCNT_RUN   = 2'd1;
  localparam logic [1:0] FCNT_TIME  = 2'd3;
  localparam logic [1:0] FCNT_DATE  = 2'd2;
  localparam logic [1:0] FCNT_ALARM = 2'd2;

  localparam logic [5:0] BLINK_F0 = 6'b110000;
  localparam logic [5:0] BLINK_F1 = 6'b001100;
  localparam logic [5:0] BLINK_F2 = 6'b000011;

  function automatic logic [1:0] field_count(page_e p);
    logic [1:0] n;
    n = FCNT_RUN;
    case (p)
      PG_TIME:  n = FCNT_TIME;
      PG_DATE:  n = FCNT_DATE;
      PG_ALARM: n = FCNT_ALARM;
      default:  n = FCNT_RUN;
    endcase
    return n;
  endfunction

  function automatic tgt_e field_tgt(page_e p, logic [1:0] f);
    tgt_e t;
    t = TGT_NONE;
    case (p)
      PG_TIME: begin
        case (f)
          2'd0:    t = TGT_HR;
          2'd1:    t = TGT_MIN;
          2'd2:    t = TGT_SEC;
          default: t = TGT_NONE;
        endcase
      end
      PG_DATE:  t = (f == 2'd0) ? TGT_MM  : TGT_DD;
      PG_ALARM: t = (f == 2'd0) ? TGT_AHR : TGT_AMIN;
      default:  t = TGT_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [5:0] blink_mask(logic [1:0] f);
    logic [5:0] m;
    m = 6'b000000;
    case (f)
      2'd0:    m = BLINK_F0;
      2'd1:    m = BLINK_F1;
      2'd2:    m = BLINK_F2;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/set_ctrl_if.sv
// Button/tick inputs and page, field, adjust and display outputs of set_ctrl.
interface set_ctrl_if;
  import set_pkg::*;

  logic               enb;
  logic [NUM_BTN-1:0] btn;
  logic [1:0]         page;
  logic [1:0]         field;
  logic [2:0]         adj_tgt;
  logic               adj_up;
  logic               adj_dn;
  logic               clk_hold;
  logic [5:0]         blink;

  modport master (
    output enb, btn,
    input  page, field, adj_tgt, adj_up, adj_dn, clk_hold, blink
  );

  modport slave (
    input  enb, btn,
    output page, field, adj_tgt, adj_up, adj_dn, clk_hold, blink
  );
endinterface

// File: rtl/set_ctrl_btn_cond.sv
// One push-button conditioner: 2-flop synchronizer, stability-count debounce
// and rising-edge detect. The level adopts the pin state after reset silently.
module btn_cond #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_init;

  // The first two cycles after reset load the level without an edge, so a
  // button held through reset release never reports a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
      r_init  <= 2'd0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_init != 2'd2) begin
        r_init  <= r_init + 2'd1;
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/set_ctrl.sv
// Set-mode sequencer: page/field FSM, auto-repeat, idle timeout and blink
// phase, issuing one-cycle adjust commands to the time/date/alarm counters.
module set_ctrl
  import set_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 250000,
  parameter int unsigned TIMEOUT   = 30,
  parameter int unsigned RPT_DELAY = 2
) (
  input logic       clk,
  input logic       rst,
  set_ctrl_if.slave bus
);

  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RPT_DELAY + 2);

  logic [NUM_BTN-1:0] w_lvl;
  logic [NUM_BTN-1:0] w_press;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .clk     (clk),
      .rst     (rst),
      .i_pin   (bus.btn[i]),
      .o_level (w_lvl[i]),
      .o_press (w_press[i])
    );
  end

  page_e         r_page,  w_page_nxt;
  logic [1:0]    r_field, w_field_nxt;
  logic [IW-1:0] r_idle,  w_idle_nxt;
  logic [RW-1:0] r_rpt,   w_rpt_nxt;
  logic          r_phase, w_phase_nxt;

  tgt_e          r_adj_tgt,  w_adj_tgt_nxt;
  logic          r_adj_up,   w_adj_up_nxt;
  logic          r_adj_dn,   w_adj_dn_nxt;
  logic          r_clk_hold, w_clk_hold_nxt;
  logic [5:0]    r_blink,    w_blink_nxt;

  logic w_set, w_any, w_mode, w_next, w_to;
  logic w_one_held, w_fire, w_up_req, w_dn_req, w_adj_ok;

  assign w_set  = (r_page != PG_RUN);
  assign w_any  = |w_press;
  assign w_mode = w_press[BTN_MODE];
  assign w_next = w_press[BTN_NEXT] & ~w_mode;
  assign w_to   = w_set & bus.enb & ~w_any & (r_idle == IW'(TIMEOUT - 1));

  // Repeat qualifies only while exactly one of UP/DOWN is held on its own.
  assign w_one_held = (w_lvl[BTN_UP] ^ w_lvl[BTN_DN]) & ~w_lvl[BTN_MODE] & ~w_lvl[BTN_NEXT];
  assign w_fire     = bus.enb & w_one_held & (r_rpt == RW'(RPT_DELAY));
  assign w_up_req   = w_press[BTN_UP] | (w_fire & w_lvl[BTN_UP]);
  assign w_dn_req   = w_press[BTN_DN] | (w_fire & w_lvl[BTN_DN]);
  assign w_adj_ok   = w_set & ~w_press[BTN_MODE] & ~w_press[BTN_NEXT] & ~w_to &
                      ~(w_lvl[BTN_UP] & w_lvl[BTN_DN]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_page     <= PG_RUN;
      r_field    <= 2'd0;
      r_idle     <= '0;
      r_rpt      <= '0;
      r_phase    <= 1'b0;
      r_adj_tgt  <= TGT_NONE;
      r_adj_up   <= 1'b0;
      r_adj_dn   <= 1'b0;
      r_clk_hold <= 1'b0;
      r_blink    <= 6'b000000;
    end else begin
      r_page     <= w_page_nxt;
      r_field    <= w_field_nxt;
      r_idle     <= w_idle_nxt;
      r_rpt      <= w_rpt_nxt;
      r_phase    <= w_phase_nxt;
      r_adj_tgt  <= w_adj_tgt_nxt;
      r_adj_up   <= w_adj_up_nxt;
      r_adj_dn   <= w_adj_dn_nxt;
      r_clk_hold <= w_clk_hold_nxt;
      r_blink    <= w_blink_nxt;
    end
  end

  // Next page/field and the repeat, idle and phase counters.
  always_comb begin
    w_page_nxt  = r_page;
    w_field_nxt = r_field;
    w_idle_nxt  = r_idle;
    w_rpt_nxt   = r_rpt;
    w_phase_nxt = r_phase;

    if (w_mode) begin
      w_page_nxt  = page_e'(r_page + 2'd1);
      w_field_nxt = 2'd0;
    end else if (w_to) begin
      w_page_nxt  = PG_RUN;
      w_field_nxt = 2'd0;
    end else if (w_next && w_set) begin
      w_field_nxt = (r_field == field_count(r_page) - 2'd1) ? 2'd0 : r_field + 2'd1;
    end

    if (w_any || !w_set || w_to) begin
      w_idle_nxt = '0;
    end else if (bus.enb) begin
      w_idle_nxt = r_idle + IW'(1);
    end

    if (!w_one_held) begin
      w_rpt_nxt = '0;
    end else if (bus.enb && (r_rpt != RW'(RPT_DELAY))) begin
      w_rpt_nxt = r_rpt + RW'(1);
    end

    if (w_any || (w_page_nxt != r_page)) begin
      w_phase_nxt = 1'b0;
    end else if (bus.enb) begin
      w_phase_nxt = ~r_phase;
    end
  end

  // Registered outputs follow the next state so page and clk_hold move together.
  always_comb begin
    w_adj_tgt_nxt  = TGT_NONE;
    w_adj_up_nxt   = 1'b0;
    w_adj_dn_nxt   = 1'b0;
    w_clk_hold_nxt = (w_page_nxt == PG_TIME);
    w_blink_nxt    = 6'b000000;

    if (w_adj_ok && (w_up_req ^ w_dn_req)) begin
      w_adj_up_nxt  = w_up_req;
      w_adj_dn_nxt  = w_dn_req;
      w_adj_tgt_nxt = field_tgt(r_page, r_field);
    end

    if ((w_page_nxt != PG_RUN) && w_phase_nxt) begin
      w_blink_nxt = blink_mask(w_field_nxt);
    end
  end

  assign bus.page     = r_page;
  assign bus.field    = r_field;
  assign bus.adj_tgt  = r_adj_tgt;
  assign bus.adj_up   = r_adj_up;
  assign bus.adj_dn   = r_adj_dn;
  assign bus.clk_hold = r_clk_hold;
  assign bus.blink    = r_blink;

endmodule

// File: tb/tb_set_ctrl.sv
// Bench for set_ctrl: press-table vectors, multi-cycle corner sequences and
// random press/tick traffic against a page/field reference model.
module tb_set_ctrl;

  localparam int DB   = 4;
  localparam int TMO  = 30;
  localparam int RPT  = 2;
  localparam int HOLD = DB + 8;

  logic clk = 1'b0;
  logic rst;

  set_ctrl_if b();

  set_ctrl #(
    .DB_CYCLES (DB),
    .TIMEOUT   (TMO),
    .RPT_DELAY (RPT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bad_form = 0;

  typedef struct {
    logic       up;
    logic [2:0] tgt;
  } pulse_t;

  pulse_t pq[$];
  pulse_t mon_p;

  // Record every adjust pulse; count malformed output cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (b.adj_up || b.adj_dn) begin
        mon_p.up  = b.adj_up;
        mon_p.tgt = b.adj_tgt;
        pq.push_back(mon_p);
        if ((b.adj_up && b.adj_dn) || (b.adj_tgt == 3'd0)) bad_form++;
      end else if (b.adj_tgt != 3'd0) begin
        bad_form++;
      end
    end
  end

  typedef struct {
    logic [3:0] btn;
    int page;
    int field;
    int np;
    int up;
    int tgt;
  } vec_t;

  vec_t vecs[25];

  int tgt_tab[4][3] = '{'{0, 0, 0}, '{1, 2, 3}, '{4, 5, 0}, '{6, 7, 0}};
  int fcnt[4]       = '{1, 3, 2, 2};
  int bmask[3]      = '{48, 12, 3};

  int mpage, mfield, midle, mphase;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    b.btn = b.btn | m;
    cyc(HOLD);
    b.btn = b.btn & ~m;
    cyc(HOLD);
  endtask

  task automatic tick();
    b.enb = 1'b1;
    cyc(1);
    b.enb = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    b.btn = 4'b0000;
    b.enb = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(4);
    pq.delete();
  endtask

  task automatic chk_state(input string name, input int pg, input int fl, input int bl);
    chk({name, " page"}, int'(b.page), pg);
    chk({name, " field"}, int'(b.field), fl);
    chk({name, " clk_hold"}, int'(b.clk_hold), (pg == 1) ? 1 : 0);
    chk({name, " blink"}, int'(b.blink), bl);
  endtask

  task automatic chk_pulses(input string name, input int n, input int up, input int tgt);
    chk({name, " pulse count"}, pq.size(), n);
    foreach (pq[i]) begin
      chk({name, " pulse dir"}, int'(pq[i].up), up);
      chk({name, " pulse tgt"}, int'(pq[i].tgt), tgt);
    end
    chk({name, " pulse form"}, bad_form, 0);
    pq.delete();
  endtask

  task automatic model_tick();
    if (mpage != 0) begin
      midle++;
      if (midle == TMO) begin
        mpage  = 0;
        mfield = 0;
        midle  = 0;
        mphase = 0;
      end else begin
        mphase ^= 1;
      end
    end else begin
      mphase ^= 1;
    end
  endtask

  function automatic int model_blink();
    return (mpage != 0 && mphase == 1) ? bmask[mfield] : 0;
  endfunction

  initial begin
    vecs[0]  = '{4'b0001, 1, 0, 0, 0, 0};
    vecs[1]  = '{4'b0010, 1, 1, 0, 0, 0};
    vecs[2]  = '{4'b0010, 1, 2, 0, 0, 0};
    vecs[3]  = '{4'b0100, 1, 2, 1, 1, 3};
    vecs[4]  = '{4'b0010, 1, 0, 0, 0, 0};
    vecs[5]  = '{4'b1000, 1, 0, 1, 0, 1};
    vecs[6]  = '{4'b0001, 2, 0, 0, 0, 0};
    vecs[7]  = '{4'b0010, 2, 1, 0, 0, 0};
    vecs[8]  = '{4'b0100, 2, 1, 1, 1, 5};
    vecs[9]  = '{4'b1100, 2, 1, 0, 0, 0};
    vecs[10] = '{4'b0010, 2, 0, 0, 0, 0};
    vecs[11] = '{4'b0101, 3, 0, 0, 0, 0};
    vecs[12] = '{4'b0010, 3, 1, 0, 0, 0};
    vecs[13] = '{4'b1000, 3, 1, 1, 0, 7};
    vecs[14] = '{4'b0010, 3, 0, 0, 0, 0};
    vecs[15] = '{4'b0100, 3, 0, 1, 1, 6};
    vecs[16] = '{4'b0001, 0, 0, 0, 0, 0};
    vecs[17] = '{4'b0010, 0, 0, 0, 0, 0};
    vecs[18] = '{4'b0100, 0, 0, 0, 0, 0};
    vecs[19] = '{4'b0001, 1, 0, 0, 0, 0};
    vecs[20] = '{4'b0010, 1, 1, 0, 0, 0};
    vecs[21] = '{4'b0011, 2, 0, 0, 0, 0};
    vecs[22] = '{4'b0110, 2, 1, 0, 0, 0};
    vecs[23] = '{4'b0001, 3, 0, 0, 0, 0};
    vecs[24] = '{4'b0001, 0, 0, 0, 0, 0};

    // Reset values while reset is held.
    rst   = 1'b1;
    b.btn = 4'b0000;
    b.enb = 1'b0;
    cyc(3);
    chk_state("reset", 0, 0, 0);
    chk("reset adj_tgt", int'(b.adj_tgt), 0);
    chk("reset adj_up", int'(b.adj_up), 0);
    chk("reset adj_dn", int'(b.adj_dn), 0);
    rst = 1'b0;
    cyc(4);
    pq.delete();

    // Press latency: page moves on the edge after press (2 + DB edges).
    b.btn[0] = 1'b1;
    cyc(2 + DB);
    chk("latency before", int'(b.page), 0);
    cyc(1);
    chk("latency after", int'(b.page), 1);
    b.btn[0] = 1'b0;
    cyc(HOLD);

    // Press table from a fresh reset.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      press(vecs[i].btn);
      chk_state($sformatf("vec%0d", i), vecs[i].page, vecs[i].field, 0);
      chk_pulses($sformatf("vec%0d", i), vecs[i].np, vecs[i].up, vecs[i].tgt);
    end

    // Auto-repeat: hold UP for 5 ticks in SET_DATE.
    do_reset();
    press(4'b0001);
    press(4'b0001);
    chk_state("rpt entry", 2, 0, 0);
    b.btn[2] = 1'b1;
    cyc(HOLD);
    for (int t = 0; t < 5; t++) tick();
    b.btn[2] = 1'b0;
    cyc(HOLD);
    tick();
    chk_pulses("repeat", 4, 1, 4);

    // Timeout in SET_ALARM with blink on alternate ticks.
    press(4'b0001);
    chk_state("tmo entry", 3, 0, 0);
    for (int t = 1; t <= TMO; t++) begin
      tick();
      if (t < TMO) begin
        chk($sformatf("tmo t%0d page", t), int'(b.page), 3);
        chk($sformatf("tmo t%0d blink", t), int'(b.blink), (t % 2 == 1) ? 48 : 0);
      end else begin
        chk_state("tmo end", 0, 0, 0);
      end
    end
    chk_pulses("tmo", 0, 0, 0);

    // Bouncing MODE pin never qualifies.
    for (int i = 0; i < 10; i++) begin
      b.btn[0] = ~b.btn[0];
      cyc(2);
    end
    cyc(HOLD);
    chk_state("bounce", 0, 0, 0);

    // Reset while UP is held in SET_TIME.
    do_reset();
    press(4'b0001);
    b.btn[2] = 1'b1;
    cyc(HOLD);
    chk_pulses("hold first", 1, 1, 1);
    chk_state("hold pre-rst", 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_state("rst async", 0, 0, 0);
    chk("rst async adj_up", int'(b.adj_up), 0);
    cyc(3);
    rst = 1'b0;
    cyc(4);
    pq.delete();
    press(4'b0001);
    chk_state("rst rehold", 1, 0, 0);
    tick();
    tick();
    chk_pulses("rst early", 0, 0, 0);
    tick();
    chk_pulses("rst requal", 1, 1, 1);
    b.btn = 4'b0000;
    cyc(HOLD);

    // Random presses and ticks against the reference model.
    do_reset();
    mpage  = 0;
    mfield = 0;
    midle  = 0;
    mphase = 0;
    for (int it = 0; it < 160; it++) begin
      int r;
      logic [3:0] m;
      int np, up, tgt;
      r = int'($urandom_range(0, 19));
      np = 0;
      up = 0;
      tgt = 0;
      if (r < 8) begin
        tick();
        model_tick();
      end else if (r == 19) begin
        int n;
        n = int'($urandom_range(20, 32));
        for (int k = 0; k < n; k++) begin
          tick();
          model_tick();
        end
      end else begin
        if (r < 16) m = 4'(1 << $urandom_range(0, 3));
        else        m = 4'($urandom_range(1, 15));
        if (m[0]) begin
          mpage  = (mpage + 1) % 4;
          mfield = 0;
        end else if (m[1]) begin
          if (mpage != 0) mfield = (mfield + 1) % fcnt[mpage];
        end else if ((m[2] != m[3]) && (mpage != 0)) begin
          np  = 1;
          up  = m[2] ? 1 : 0;
          tgt = tgt_tab[mpage][mfield];
        end
        midle  = 0;
        mphase = 0;
        press(m);
      end
      chk_state($sformatf("rnd%0d", it), mpage, mfield, model_blink());
      chk_pulses($sformatf("rnd%0d", it), np, up, tgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/set_ctrl.md
# set_ctrl

Set-mode sequencer for the clock/date/alarm datapath. Conditions the four push-buttons, steps a page/field state machine (run, set time, set date, set alarm), and issues single-cycle increment/decrement commands tagged with a target field to the time, date and alarm counters. It sits between the raw `btn[3:0]` pins and the counter blocks, and also drives the display page select and a per-digit blink mask for the six seven-segment digits.

## Interface
- `DB_CYCLES`, default 250000: clk cycles a button level must be stable before it is accepted.
- `TIMEOUT`, default 30: `enb` ticks without a press before auto-return to RUN.
- `RPT_DELAY`, default 2: `enb` ticks UP/DOWN must be held before auto-repeat starts.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enb`  in  1  one-cycle 1 Hz tick, synchronous to `clk`.
- `btn`  in  4  raw buttons: [0] MODE, [1] NEXT, [2] UP, [3] DOWN.
- `page`  out  2  0 RUN, 1 SET_TIME, 2 SET_DATE, 3 SET_ALARM.
- `field`  out  2  selected field index within the page.
- `adj_tgt`  out  3  0 none, 1 hr, 2 min, 3 sec, 4 mm, 5 dd, 6 a_hr, 7 a_min.
- `adj_up`  out  1  one-cycle increment command for `adj_tgt`.
- `adj_dn`  out  1  one-cycle decrement command for `adj_tgt`.
- `clk_hold`  out  1  high in SET_TIME; time counter must freeze.
- `blink`  out  6  digit blank mask, bit5 = leftmost digit.

## Operation
- Each button: 2-flop synchronizer, stability counter (DB_CYCLES), rising-edge detector producing a one-cycle `press`; the debounced level is also kept for hold detection.
- Page FSM on MODE press: RUN -> SET_TIME -> SET_DATE -> SET_ALARM -> RUN. Every page change resets `field` to 0.
- NEXT press: `field` advances modulo field count (SET_TIME 3: hr, min, sec; SET_DATE 2: mm, dd; SET_ALARM 2: a_hr, a_min). Ignored in RUN.
- UP/DOWN press in a set page: `adj_up`/`adj_dn` high for exactly one cycle, with `adj_tgt` equal to the selected field's code in the same cycle. Ignored in RUN. `adj_tgt` = 0 whenever no pulse is asserted.
- Auto-repeat: UP or DOWN held continuously for RPT_DELAY `enb` ticks issues one extra pulse on every following `enb` until release.
- Priority in one cycle: MODE > NEXT > UP/DOWN. UP and DOWN together issue no pulse.
- Timeout: an idle counter clears on any press and increments on `enb` in set pages. At TIMEOUT it returns to RUN with `field` = 0.
- Blink: a phase bit toggles on each `enb` and clears on any press or page change. When phase = 1 in a set page, the selected field's digit pair is set: field0 110000, field1 001100, field2 000011. `blink` = 0 in RUN.
- Range wrap and clamping of values belong to the counter blocks, not to this block.

## Timing
- All outputs are registered. Reset values: `page` 0, `field` 0, `adj_tgt` 0, `adj_up` 0, `adj_dn` 0, `clk_hold` 0, `blink` 0. Debounce, repeat, idle and phase state also clear on reset.
- Latency: `press` is high 2 + DB_CYCLES cycles after a stable pin edge. The outputs update on the following clk edge.
- `clk_hold` changes in the same cycle as `page`.
- Reset asserted mid-hold: no pulse is issued after reset release until a fresh press or a full RPT_DELAY re-qualifies the hold.
- A button still held during reset release must not generate a press. The debounced level initializes to the current stable value, not 0.

## Structure
- Package `set_pkg` holds the page encodings, the `adj_tgt` codes, the per-page field counts and the blink masks.
- Sub-module `btn_cond`: synchronizer, debounce and edge detect for one button. Instanced four times. Outputs `level` and `press`.
- Top level contains the page/field FSM, the repeat/idle/phase counters and the output registers.

## Test plan
- Reset, then MODE pressed 4 times (DB_CYCLES = 4 in sim) -> `page` steps 1, 2, 3, 0. `clk_hold` is 1 only at page 1.
- SET_TIME, NEXT ×2, UP -> one-cycle `adj_up` with `adj_tgt` = 3. NEXT again gives `field` = 0.
- SET_DATE, hold UP for 5 `enb` ticks with RPT_DELAY = 2 -> 1 press pulse + 3 repeat pulses, all with `adj_tgt` = 4.
- SET_ALARM, no buttons for 30 `enb` -> `page` = 0 and `blink` = 000000. Blink observed as 110000 on alternate ticks before the timeout.
- Bouncing pin (toggle every 2 cycles for 20 cycles) -> no press. UP+DOWN simultaneously -> no pulse. MODE+UP simultaneously -> page advances, no pulse.
- `rst` asserted while UP held in SET_TIME -> all outputs 0 immediately. No pulse after release while UP stays held until RPT_DELAY elapses.
